// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 serial transmitter with a byte FIFO and a status register.
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   address, write_en CPU bus address and write strobe
//   data_in           CPU write data (BASE_ADDR: byte to send, BASE_ADDR+1: bit2 clears overflow)
//   data_out          combinational read data; status at BASE_ADDR+1 = {5'b0, overflow, idle_empty, not_full}
//   sel               high when address hits BASE_ADDR or BASE_ADDR+1
//   tx                serial line, idle high
//   irq               registered; high when the FIFO is empty and the transmitter is idle
module mmio_uart_tx #(
    parameter logic [15:0] BASE_ADDR    = 16'hF200,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_AW      = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic        write_en,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        sel,
    output logic        tx,
    output logic        irq
);
    localparam int DEPTH = 1 << FIFO_AW;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t             state_q, state_d;
    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q, count_d;
    logic [15:0]        baud_q, baud_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d, ovf_q, ovf_d, irq_q;
    logic               sel_data, sel_stat, push_req, push, pop, empty, full, baud_tc;

    assign sel_data = address == BASE_ADDR;
    assign sel_stat = address == BASE_ADDR + 16'd1;
    assign sel      = sel_data | sel_stat;
    assign empty    = count_q == '0;
    // count never exceeds DEPTH, so its top bit alone means full
    assign full     = count_q[FIFO_AW];
    assign baud_tc  = baud_q == 16'(CLKS_PER_BIT - 1);
    assign push_req = write_en & sel_data;
    // a full FIFO still accepts a byte when the head leaves on the same edge
    assign push     = push_req & (~full | pop);
    assign count_d  = count_q + {{FIFO_AW{1'b0}}, push} - {{FIFO_AW{1'b0}}, pop};
    // a dropped byte sets overflow even if a clear arrives on the same edge
    assign ovf_d    = (push_req & ~push) | (ovf_q & ~(write_en & sel_stat & data_in[2]));
    assign data_out = sel_stat ? {5'b0, ovf_q, empty & (state_q == IDLE), ~full} : 8'h00;
    assign tx       = tx_q;
    assign irq      = irq_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 16'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: if (baud_tc) begin
                baud_d  = '0;
                bit_d   = '0;
                tx_d    = shift_q[0];
                state_d = DATA;
            end
            DATA: if (baud_tc) begin
                baud_d = '0;
                if (bit_q == 3'd7) begin
                    tx_d    = 1'b1;
                    state_d = STOP;
                end else begin
                    bit_d   = bit_q + 3'd1;
                    shift_d = shift_q >> 1;
                    tx_d    = shift_q[1];
                end
            end
            STOP: if (baud_tc) begin
                baud_d = '0;
                // chain straight into the next start bit so frames stay contiguous
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    tx_d    = 1'b0;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= data_in;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= push ? wr_ptr_q + 1'b1 : wr_ptr_q;
            rd_ptr_q <= pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
            count_q  <= count_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            ovf_q    <= ovf_d;
            irq_q    <= (count_d == '0) && (state_d == IDLE);
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed self-checking bench for mmio_uart_tx with a serial-line decoder.
module tb_mmio_uart_tx;
    localparam int CPB = 4;
    logic        clock = 1'b0, reset = 1'b1, write_en = 1'b0;
    logic [15:0] address = 16'h0000;
    logic [7:0]  data_in = 8'h00, data_out;
    logic        sel, tx, irq;
    int          tests = 0, fails = 0, cyc = 0, mon_t = -1, mon_start = 0;
    logic [7:0]  mon_b = 8'h00;
    logic [7:0]  rx_q[$];
    int          rx_t[$];

    mmio_uart_tx #(.BASE_ADDR(16'hF200), .CLKS_PER_BIT(CPB), .FIFO_AW(3)) dut (
        .clock(clock), .reset(reset), .address(address), .write_en(write_en),
        .data_in(data_in), .data_out(data_out), .sel(sel), .tx(tx), .irq(irq)
    );

    always #5 clock = ~clock;

    // line decoder: samples mid-bit, records each byte and the cycle its start bit began
    initial begin
        int k;
        forever begin
            @(negedge clock);
            cyc++;
            if (reset) mon_t = -1;
            else if (mon_t < 0) begin
                if (tx === 1'b0) begin
                    mon_t = 0;
                    mon_start = cyc;
                end
            end else mon_t++;
            if (!reset && mon_t >= 0 && mon_t % CPB == CPB / 2) begin
                k = mon_t / CPB;
                if (k == 0 && tx !== 1'b0) begin
                    tests++; fails++;
                    $display("FAIL start_bit: tx=%b required 0 at cycle %0d", tx, cyc);
                    mon_t = -1;
                end else if (k >= 1 && k <= 8) mon_b[k-1] = tx;
                else if (k == 9) begin
                    tests++;
                    if (tx !== 1'b1) begin
                        fails++;
                        $display("FAIL stop_bit: tx=%b required 1 at cycle %0d", tx, cyc);
                    end
                    rx_q.push_back(mon_b);
                    rx_t.push_back(mon_start);
                    mon_t = -1;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write(input logic [15:0] a, input logic [7:0] d);
        address = a; data_in = d; write_en = 1'b1;
        tick();
        write_en = 1'b0; address = 16'h0000; data_in = 8'h00;
    endtask

    task automatic wait_frames(input int n, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            if (rx_q.size() >= n) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        address = 16'hF201;
        #1;
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            if (data_out === 8'h03 && irq === 1'b1) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        tests++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b want 1", tx); end
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b want 0", irq); end
        address = 16'hF201; #1;
        tests++; if (data_out !== 8'h03) begin fails++; $display("FAIL reset_status: got %h want 03", data_out); end
        reset = 1'b0;
        tick();
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL reset_irq_rise: got %b want 1", irq); end
        tick(); tick();
    endtask

    task automatic test_single_byte();
        logic [9:0] frame;
        bit ok;
        frame = {1'b1, 8'h55, 1'b0};
        rx_q.delete(); rx_t.delete();
        write(16'hF200, 8'h55);
        tests++; if (tx !== 1'b1 || irq !== 1'b0) begin fails++; $display("FAIL single_write_edge: tx=%b irq=%b want tx=1 irq=0", tx, irq); end
        for (int i = 0; i < 10 * CPB; i++) begin
            tick();
            tests++;
            if (tx !== frame[i / CPB] || irq !== 1'b0) begin
                fails++;
                $display("FAIL single_frame[%0d]: tx=%b irq=%b want tx=%b irq=0", i, tx, irq, frame[i / CPB]);
            end
        end
        tick();
        tests++; if (tx !== 1'b1 || irq !== 1'b1) begin fails++; $display("FAIL single_end: tx=%b irq=%b want 1 1", tx, irq); end
        wait_frames(1, 20, ok);
        tests++; if (!ok || rx_q[0] !== 8'h55) begin fails++; $display("FAIL single_rx: got %0d frames first %h want 55", rx_q.size(), rx_q.size() ? rx_q[0] : 8'h00); end
    endtask

    task automatic test_status();
        bit ok;
        address = 16'hF201; #1;
        tests++; if (data_out !== 8'h03 || sel !== 1'b1) begin fails++; $display("FAIL status_idle: data=%h sel=%b want 03 1", data_out, sel); end
        address = 16'hF200; #1;
        tests++; if (data_out !== 8'h00 || sel !== 1'b1) begin fails++; $display("FAIL data_read: data=%h sel=%b want 00 1", data_out, sel); end
        address = 16'hF202; #1;
        tests++; if (data_out !== 8'h00 || sel !== 1'b0) begin fails++; $display("FAIL unmapped_read: data=%h sel=%b want 00 0", data_out, sel); end
        rx_q.delete(); rx_t.delete();
        write(16'hF200, 8'hA5);
        address = 16'hF201; #1;
        tests++; if (data_out !== 8'h01) begin fails++; $display("FAIL status_after_write: got %h want 01", data_out); end
        tick();
        tests++; if (data_out !== 8'h01) begin fails++; $display("FAIL status_sending: got %h want 01", data_out); end
        wait_idle(100, ok);
        tests++; if (!ok) begin fails++; $display("FAIL status_drain: status=%h irq=%b want 03 1", data_out, irq); end
        tests++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin fails++; $display("FAIL status_rx: %0d frames want 1 of A5", rx_q.size()); end
    endtask

    task automatic test_burst_overflow();
        bit ok;
        rx_q.delete(); rx_t.delete();
        for (int i = 0; i < 10; i++) begin
            address = 16'hF200; data_in = 8'(8'h41 + i); write_en = 1'b1;
            tick();
        end
        write_en = 1'b0; address = 16'hF201; #1;
        tests++; if (data_out !== 8'h04) begin fails++; $display("FAIL burst_status: got %h want 04", data_out); end
        write(16'hF201, 8'h03);
        address = 16'hF201; #1;
        tests++; if (data_out !== 8'h04) begin fails++; $display("FAIL ovf_no_clear: got %h want 04", data_out); end
        write(16'hF201, 8'h04);
        address = 16'hF201; #1;
        tests++; if (data_out !== 8'h00) begin fails++; $display("FAIL ovf_clear: got %h want 00", data_out); end
        wait_frames(9, 9 * 10 * CPB + 50, ok);
        tests++; if (!ok) begin fails++; $display("FAIL burst_frames: got %0d want 9", rx_q.size()); end
        for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
            tests++;
            if (rx_q[i] !== 8'(8'h41 + i)) begin fails++; $display("FAIL burst_byte[%0d]: got %h want %h", i, rx_q[i], 8'(8'h41 + i)); end
        end
        for (int i = 0; i + 1 < rx_t.size(); i++) begin
            tests++;
            if (rx_t[i+1] - rx_t[i] != 10 * CPB) begin fails++; $display("FAIL burst_gap[%0d]: got %0d want %0d", i, rx_t[i+1] - rx_t[i], 10 * CPB); end
        end
        wait_idle(100, ok);
        tests++; if (!ok || rx_q.size() != 9) begin fails++; $display("FAIL burst_idle: status=%h frames=%0d want 03 9", data_out, rx_q.size()); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        rx_q.delete(); rx_t.delete();
        for (int i = 0; i < 9; i++) begin
            address = 16'hF200; data_in = 8'(8'h70 + i); write_en = 1'b1;
            tick();
        end
        write_en = 1'b0;
        repeat (32) tick();
        address = 16'hF201; #1;
        tests++; if (data_out !== 8'h00 || tx !== 1'b1) begin fails++; $display("FAIL full_before: status=%h tx=%b want 00 1", data_out, tx); end
        write(16'hF200, 8'h7E);
        address = 16'hF201; #1;
        tests++; if (data_out !== 8'h00 || tx !== 1'b0) begin fails++; $display("FAIL pushpop_edge: status=%h tx=%b want 00 0", data_out, tx); end
        wait_frames(10, 10 * 10 * CPB + 50, ok);
        tests++; if (!ok) begin fails++; $display("FAIL pushpop_frames: got %0d want 10", rx_q.size()); end
        for (int i = 0; i < 9 && i < rx_q.size(); i++) begin
            tests++;
            if (rx_q[i] !== 8'(8'h70 + i)) begin fails++; $display("FAIL pushpop_byte[%0d]: got %h want %h", i, rx_q[i], 8'(8'h70 + i)); end
        end
        tests++; if (rx_q.size() < 10 || rx_q[9] !== 8'h7E) begin fails++; $display("FAIL pushpop_last: frames=%0d want 7E last", rx_q.size()); end
        wait_idle(100, ok);
        tests++; if (!ok) begin fails++; $display("FAIL pushpop_idle: status=%h want 03", data_out); end
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        rx_q.delete(); rx_t.delete();
        write(16'hF200, 8'h5A);
        write(16'hF200, 8'h11);
        write(16'hF200, 8'h22);
        write(16'hF200, 8'h33);
        repeat (11) tick();
        tests++; if (tx !== 1'b0) begin fails++; $display("FAIL midframe_bit2: got %b want 0", tx); end
        repeat (3) tick();
        tests++; if (tx !== 1'b1) begin fails++; $display("FAIL midframe_bit3: got %b want 1", tx); end
        reset = 1'b1;
        tick();
        address = 16'hF201; #1;
        tests++; if (tx !== 1'b1 || irq !== 1'b0 || data_out !== 8'h03) begin fails++; $display("FAIL midframe_reset: tx=%b irq=%b status=%h want 1 0 03", tx, irq, data_out); end
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (tx !== 1'b1) bad++;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL midframe_quiet: %0d low cycles want 0", bad); end
        tests++; if (rx_q.size() != 0) begin fails++; $display("FAIL midframe_rx: %0d frames want 0", rx_q.size()); end
        tests++; if (data_out !== 8'h03 || irq !== 1'b1) begin fails++; $display("FAIL midframe_status: status=%h irq=%b want 03 1", data_out, irq); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_status();
        test_burst_overflow();
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
